// File: rtl/cpu_pkg.sv
// Shared CPU front-end types and constants.
package cpu_pkg;

   localparam int unsigned INSTR_W  = 32;
   localparam int unsigned IFID_PCW = 64;  // PC field width in the IF/ID record
   localparam logic [INSTR_W-1:0] NOP_INSTR = 32'hD503201F;

   // IF/ID pipeline record handed to decode.
   typedef struct packed {
      logic [INSTR_W-1:0]  instr;
      logic [IFID_PCW-1:0] pc;
      logic                valid;
   } ifid_t;

endpackage

// File: rtl/branch_target_calc.sv
// Branch target: base PC plus sign-extended word offset, modulo 2^PC_W.
module branch_target_calc #(
   parameter int unsigned PC_W = 64
) (
   input  logic [PC_W-1:0] br_pc,
   input  logic            uncond_br,
   input  logic [18:0]     cond_addr19,
   input  logic [25:0]     br_addr26,
   output logic [PC_W-1:0] target
);

   logic [PC_W-1:0] off_sext;

   // Select the offset field, sign-extend, convert words to bytes and add.
   always_comb begin
      off_sext = '0;
      if (uncond_br) begin
         off_sext = {{(PC_W-26){br_addr26[25]}}, br_addr26};
      end else begin
         off_sext = {{(PC_W-19){cond_addr19[18]}}, cond_addr19};
      end
      target = br_pc + (off_sext << 2);
   end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC register, next-PC selection, IF/ID register and fetch counter.
module fetch_stage
   import cpu_pkg::*;
#(
   parameter int unsigned     PC_W     = 64,  // must not exceed IFID_PCW
   parameter logic [PC_W-1:0] RESET_PC = '0
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               stall,
   input  logic               flush,
   input  logic               br_taken,
   input  logic               uncond_br,
   input  logic [PC_W-1:0]    br_pc,
   input  logic [18:0]        cond_addr19,
   input  logic [25:0]        br_addr26,
   output logic [PC_W-1:0]    imem_addr,
   input  logic [INSTR_W-1:0] imem_rdata,
   output logic [INSTR_W-1:0] id_instr,
   output logic [PC_W-1:0]    id_pc,
   output logic               id_valid,
   output logic [31:0]        fetch_count
);

   logic [PC_W-1:0] pc_q, pc_d;
   logic [PC_W-1:0] br_target;
   ifid_t           ifid_q, ifid_d;
   logic [31:0]     fetch_count_q, fetch_count_d;
   logic            load_valid;

   branch_target_calc #(
      .PC_W (PC_W)
   ) u_br_target (
      .br_pc       (br_pc),
      .uncond_br   (uncond_br),
      .cond_addr19 (cond_addr19),
      .br_addr26   (br_addr26),
      .target      (br_target)
   );

   // Next PC: branch redirect beats stall; otherwise sequential.
   always_comb begin
      pc_d = pc_q + PC_W'(4);
      if (br_taken) begin
         pc_d = br_target;
      end else if (stall) begin
         pc_d = pc_q;
      end
   end

   // IF/ID next state: bubble on flush/redirect, hold on stall, else capture fetch.
   always_comb begin
      ifid_d     = ifid_q;
      load_valid = 1'b0;
      if (flush || br_taken) begin
         ifid_d.instr = NOP_INSTR;
         ifid_d.pc    = '0;
         ifid_d.valid = 1'b0;
      end else if (!stall) begin
         ifid_d.instr = imem_rdata;
         ifid_d.pc    = IFID_PCW'(pc_q);
         ifid_d.valid = 1'b1;
         load_valid   = 1'b1;
      end
   end

   // Saturating count of valid instructions accepted into IF/ID.
   always_comb begin
      fetch_count_d = fetch_count_q;
      if (load_valid && (fetch_count_q != 32'hFFFF_FFFF)) begin
         fetch_count_d = fetch_count_q + 32'd1;
      end
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         pc_q          <= RESET_PC;
         ifid_q.instr  <= NOP_INSTR;
         ifid_q.pc     <= '0;
         ifid_q.valid  <= 1'b0;
         fetch_count_q <= '0;
      end else begin
         pc_q          <= pc_d;
         ifid_q        <= ifid_d;
         fetch_count_q <= fetch_count_d;
      end
   end

   // Memory address comes straight from the register, never from branch control.
   assign imem_addr   = pc_q;
   assign id_instr    = ifid_q.instr;
   assign id_pc       = ifid_q.pc[PC_W-1:0];
   assign id_valid    = ifid_q.valid;
   assign fetch_count = fetch_count_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage; a second instance covers a wrapping reset PC.
module tb_fetch_stage;
   import cpu_pkg::*;

   localparam logic [63:0] NOP64 = 64'h0;
   localparam logic [31:0] NOP   = 32'hD503201F;

   logic        clk = 1'b0;
   logic        reset, stall, flush, br_taken, uncond_br;
   logic [63:0] br_pc;
   logic [18:0] cond_addr19;
   logic [25:0] br_addr26;
   logic [63:0] imem_addr, id_pc, imem_addr2, id_pc2;
   logic [31:0] imem_rdata, id_instr, fetch_count, imem_rdata2, id_instr2, fetch_count2;
   logic        id_valid, id_valid2;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   // Instruction memory content model: a distinct word per address.
   function automatic logic [31:0] instr_at(input logic [63:0] a);
      return 32'hE000_0000 ^ a[31:0] ^ (a[31:0] << 12);
   endfunction

   assign imem_rdata  = instr_at(imem_addr);
   assign imem_rdata2 = instr_at(imem_addr2);

   fetch_stage #(.PC_W(64), .RESET_PC(64'h0)) dut (
      .clk(clk), .reset(reset), .stall(stall), .flush(flush), .br_taken(br_taken),
      .uncond_br(uncond_br), .br_pc(br_pc), .cond_addr19(cond_addr19),
      .br_addr26(br_addr26), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
      .id_instr(id_instr), .id_pc(id_pc), .id_valid(id_valid), .fetch_count(fetch_count)
   );

   fetch_stage #(.PC_W(64), .RESET_PC(64'hFFFF_FFFF_FFFF_FFFC)) dut2 (
      .clk(clk), .reset(reset), .stall(stall), .flush(flush), .br_taken(br_taken),
      .uncond_br(uncond_br), .br_pc(br_pc), .cond_addr19(cond_addr19),
      .br_addr26(br_addr26), .imem_addr(imem_addr2), .imem_rdata(imem_rdata2),
      .id_instr(id_instr2), .id_pc(id_pc2), .id_valid(id_valid2),
      .fetch_count(fetch_count2)
   );

   // Advance n clocks; return on the falling edge, where outputs are sampled.
   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic idle_inputs();
      stall = 0; flush = 0; br_taken = 0; uncond_br = 0;
      br_pc = '0; cond_addr19 = '0; br_addr26 = '0;
   endtask

   // Two reset cycles, then release; leaves the DUT in its reset state.
   task automatic do_reset();
      idle_inputs();
      reset = 1;
      step(2);
      reset = 0;
   endtask

   task automatic test_reset();
      do_reset();
      checks++; if (imem_addr !== 64'h0) begin errors++;
         $display("FAIL reset_pc got=%h want=%h", imem_addr, 64'h0); end
      checks++; if ({id_valid, id_instr, id_pc, fetch_count} !== {1'b0, NOP, NOP64, 32'd0}) begin
         errors++; $display("FAIL reset_ifid got v=%b i=%h pc=%h cnt=%0d want v=0 i=%h pc=0 cnt=0",
                             id_valid, id_instr, id_pc, fetch_count, NOP); end
      step(1);
      checks++; if ({imem_addr, id_pc, id_valid, id_instr, fetch_count} !==
                    {64'h4, 64'h0, 1'b1, instr_at(64'h0), 32'd1}) begin errors++;
         $display("FAIL first_load got pc=%h idpc=%h v=%b i=%h cnt=%0d want pc=4 idpc=0 v=1 i=%h cnt=1",
                  imem_addr, id_pc, id_valid, id_instr, fetch_count, instr_at(64'h0)); end
      step(1);
      checks++; if ({imem_addr, id_pc, id_instr, fetch_count} !==
                    {64'h8, 64'h4, instr_at(64'h4), 32'd2}) begin errors++;
         $display("FAIL second_load got pc=%h idpc=%h i=%h cnt=%0d want pc=8 idpc=4 cnt=2",
                  imem_addr, id_pc, id_instr, fetch_count); end
   endtask

   task automatic test_stall();
      do_reset();
      step(4);  // pc_q = 0x10, IF/ID holds PC 0xC
      stall = 1;
      for (int i = 0; i < 3; i++) begin
         step(1);
         checks++; if ({imem_addr, id_pc, id_instr, id_valid, fetch_count} !==
                       {64'h10, 64'hC, instr_at(64'hC), 1'b1, 32'd4}) begin errors++;
            $display("FAIL stall_hold[%0d] got pc=%h idpc=%h v=%b cnt=%0d want pc=10 idpc=c v=1 cnt=4",
                     i, imem_addr, id_pc, id_valid, fetch_count); end
      end
      stall = 0;
      step(1);
      checks++; if ({imem_addr, id_pc, id_instr, fetch_count} !==
                    {64'h14, 64'h10, instr_at(64'h10), 32'd5}) begin errors++;
         $display("FAIL stall_release got pc=%h idpc=%h cnt=%0d want pc=14 idpc=10 cnt=5",
                  imem_addr, id_pc, fetch_count); end
   endtask

   task automatic test_cond_branch();
      do_reset();
      step(1);  // pc 4, cnt 1
      br_pc = 64'h40; cond_addr19 = 19'h7FFFE; uncond_br = 0; br_addr26 = 26'h000123;
      br_taken = 1;
      step(1);
      br_taken = 0;
      checks++; if (imem_addr !== 64'h38) begin errors++;
         $display("FAIL cond_target got=%h want=%h", imem_addr, 64'h38); end
      checks++; if ({id_valid, id_instr, id_pc, fetch_count} !== {1'b0, NOP, NOP64, 32'd1}) begin
         errors++; $display("FAIL cond_bubble got v=%b i=%h pc=%h cnt=%0d want v=0 i=%h pc=0 cnt=1",
                             id_valid, id_instr, id_pc, fetch_count, NOP); end
      step(1);
      checks++; if ({imem_addr, id_pc, id_valid, fetch_count} !== {64'h3C, 64'h38, 1'b1, 32'd2}) begin
         errors++; $display("FAIL cond_resume got pc=%h idpc=%h v=%b cnt=%0d want pc=3c idpc=38 v=1 cnt=2",
                             imem_addr, id_pc, id_valid, fetch_count); end
   endtask

   task automatic test_uncond_branch();
      do_reset();
      step(1);
      br_pc = 64'h100; br_addr26 = 26'h000010; cond_addr19 = 19'h00005; uncond_br = 1;
      br_taken = 1;
      step(1);
      checks++; if ({imem_addr, id_valid} !== {64'h140, 1'b0}) begin errors++;
         $display("FAIL uncond_target got pc=%h v=%b want pc=140 v=0", imem_addr, id_valid); end
      do_reset();
      step(1);
      br_pc = 64'h100; br_addr26 = 26'h000010; uncond_br = 1; br_taken = 1; stall = 1;
      step(1);
      br_taken = 0; stall = 0;
      checks++; if ({imem_addr, id_valid, id_instr, fetch_count} !== {64'h140, 1'b0, NOP, 32'd1}) begin
         errors++; $display("FAIL uncond_stall got pc=%h v=%b i=%h cnt=%0d want pc=140 v=0 i=%h cnt=1",
                             imem_addr, id_valid, id_instr, fetch_count, NOP); end
   endtask

   task automatic test_wrap();
      do_reset();
      checks++; if (imem_addr2 !== 64'hFFFF_FFFF_FFFF_FFFC) begin errors++;
         $display("FAIL wrap_reset_pc got=%h want=fffffffffffffffc", imem_addr2); end
      step(1);
      checks++; if ({imem_addr2, id_pc2, id_valid2} !== {64'h0, 64'hFFFF_FFFF_FFFF_FFFC, 1'b1}) begin
         errors++; $display("FAIL wrap_seq got pc=%h idpc=%h v=%b want pc=0 idpc=fffffffffffffffc v=1",
                             imem_addr2, id_pc2, id_valid2); end
      br_pc = 64'h0; br_addr26 = 26'h3FFFFFF; uncond_br = 1; br_taken = 1;
      step(1);
      br_taken = 0;
      checks++; if (imem_addr !== 64'hFFFF_FFFF_FFFF_FFFC) begin errors++;
         $display("FAIL wrap_target got=%h want=fffffffffffffffc", imem_addr); end
   endtask

   task automatic test_flush();
      do_reset();
      step(3);  // pc 0xC, IF/ID PC 8, cnt 3
      flush = 1; stall = 1;
      step(1);
      checks++; if ({imem_addr, id_valid, id_instr, id_pc, fetch_count} !==
                    {64'hC, 1'b0, NOP, NOP64, 32'd3}) begin errors++;
         $display("FAIL flush_stall got pc=%h v=%b i=%h idpc=%h cnt=%0d want pc=c v=0 idpc=0 cnt=3",
                  imem_addr, id_valid, id_instr, id_pc, fetch_count); end
      stall = 0;
      step(1);
      flush = 0;
      checks++; if ({imem_addr, id_valid, fetch_count} !== {64'h10, 1'b0, 32'd3}) begin errors++;
         $display("FAIL flush_only got pc=%h v=%b cnt=%0d want pc=10 v=0 cnt=3",
                  imem_addr, id_valid, fetch_count); end
   endtask

   task automatic test_saturation();
      do_reset();
      force dut.fetch_count_q = 32'hFFFF_FFFE;
      step(1);
      release dut.fetch_count_q;
      step(2);
      checks++; if ({fetch_count, id_valid} !== {32'hFFFF_FFFF, 1'b1}) begin errors++;
         $display("FAIL saturate got cnt=%h v=%b want cnt=ffffffff v=1", fetch_count, id_valid); end
   endtask

   task automatic test_reset_mid();
      do_reset();
      step(3);
      stall = 1; br_taken = 1; flush = 1; br_pc = 64'h400; uncond_br = 1; reset = 1;
      step(1);
      reset = 0; idle_inputs(); stall = 1;
      checks++; if ({imem_addr, id_valid, id_instr, id_pc, fetch_count} !==
                    {64'h0, 1'b0, NOP, NOP64, 32'd0}) begin errors++;
         $display("FAIL reset_mid got pc=%h v=%b i=%h idpc=%h cnt=%0d want all reset",
                  imem_addr, id_valid, id_instr, id_pc, fetch_count); end
      stall = 0;
   endtask

   initial begin
      idle_inputs();
      reset = 1;
      test_reset();
      test_stall();
      test_cond_branch();
      test_uncond_branch();
      test_wrap();
      test_flush();
      test_saturation();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
